// File: rtl/siren_controller.sv
// rtl/siren_controller.sv - confirms an alarm request and drives an intermittent siren
// Handles operator silence, a maximum sounding time, and a saturating event counter.
module siren_controller #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int HALF_PERIOD    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       alarm_req,
  input  logic       silence,
  output logic       siren,
  output logic       sounding,
  output logic [1:0] state,
  output logic [7:0] event_count
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONFIRM  = 2'd1,
    SOUNDING = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  state_t          st;
  logic [CW-1:0]   confirm_cnt;
  logic [PW-1:0]   phase;
  logic [PW-1:0]   phase_nxt;
  logic [DW-1:0]   dur;
  logic            go_sound;

  assign state = st;

  // The request is confirmed on the edge where the run of high samples reaches CONFIRM_CYCLES.
  assign go_sound = alarm_req &&
                    (((st == IDLE) && (CONFIRM_CYCLES == 1)) ||
                     ((st == CONFIRM) && (confirm_cnt == CW'(CONFIRM_CYCLES - 1))));

  assign phase_nxt = (phase == PW'(2 * HALF_PERIOD - 1)) ? '0 : phase + 1'b1;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      siren       <= 1'b0;
      sounding    <= 1'b0;
      event_count <= '0;
      confirm_cnt <= '0;
      phase       <= '0;
      dur         <= '0;
    end else if (go_sound) begin
      st          <= SOUNDING;
      siren       <= 1'b1;
      sounding    <= 1'b1;
      confirm_cnt <= '0;
      phase       <= '0;
      dur         <= '0;
      if (event_count != 8'hFF) event_count <= event_count + 8'd1;
    end else begin
      case (st)
        IDLE: begin
          siren    <= 1'b0;
          sounding <= 1'b0;
          if (alarm_req) begin
            st          <= CONFIRM;
            confirm_cnt <= CW'(1);
          end
        end
        CONFIRM: begin
          if (alarm_req) begin
            confirm_cnt <= confirm_cnt + 1'b1;
          end else begin
            st          <= IDLE;
            confirm_cnt <= '0;
          end
        end
        SOUNDING: begin
          // Silence outranks a dropped request, which outranks the timeout.
          if (silence || !alarm_req || (dur == DW'(TIMEOUT_CYCLES - 1))) begin
            st       <= (silence || alarm_req) ? HOLDOFF : IDLE;
            siren    <= 1'b0;
            sounding <= 1'b0;
            phase    <= '0;
            dur      <= '0;
          end else begin
            dur   <= dur + 1'b1;
            phase <= phase_nxt;
            siren <= (phase_nxt < PW'(HALF_PERIOD));
          end
        end
        HOLDOFF: begin
          siren    <= 1'b0;
          sounding <= 1'b0;
          if (!alarm_req) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
